// File: rtl/instr_mem_pkg.sv
// Shared definitions for the instruction memory: FSM state encoding,
// the default fetch filler word and the default memory depth.
package instr_mem_pkg;

  // Default memory depth as log2 of the number of 32-bit words.
  localparam int unsigned DEPTH_LOG2_DEFAULT = 10;

  // RV32I canonical NOP (addi x0, x0, 0). It is returned whenever no valid
  // program word is available.
  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0013;

  // Loader state. LOAD accepts bytes. DONE and ERR are terminal until reset.
  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_DONE = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

endpackage

// File: rtl/instr_mem_ram.sv
// Simple dual-port RAM, DEPTH x 32.
// It has one synchronous write port and one synchronous read port.
// There is no reset on the array or on the read register.
// Read-during-write to the same address returns the old contents.
module instr_mem_ram
  import instr_mem_pkg::*;
#(
  parameter int unsigned AW = DEPTH_LOG2_DEFAULT,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  // Write port, and a registered read with a latency of one cycle.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/instr_mem.sv
// Instruction memory with a byte-stream program loader.
// The loader packs incoming bytes little-endian into 32-bit words and
// writes each word to the RAM as its fourth byte arrives.
// The core fetches through a registered read port. That port returns the
// NOP word until a complete program has been loaded.
//
// Loader handshake: a byte moves only in a cycle where ld_valid and ld_ready
// are both high at the rising edge of clk. ld_data and ld_last are sampled
// only in such a cycle; otherwise they are ignored. ld_ready is high exactly
// while the loader is in LOAD. ld_ready does not depend combinationally on
// ld_valid.
module instr_mem
  import instr_mem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEFAULT,
  parameter logic [31:0] NOP_WORD   = NOP_WORD_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [7:0]  ld_data,
  input  logic        ld_last,
  input  logic [31:0] instr_addr,
  output logic [31:0] instr_data,
  output logic [31:0] last_pc,
  output logic        prog_ready,
  output logic        ld_error,
  output state_e      dbg_state
);

  localparam int unsigned PW = DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH = 2**DEPTH_LOG2;
  // The write pointer reaches this value after DEPTH words have been stored.
  // Any further byte is an overflow.
  localparam logic [PW-1:0] PTR_FULL = PW'(DEPTH);

  state_e          state_q, state_d;
  logic [1:0]      byte_cnt_q, byte_cnt_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [23:0]     word_buf_q, word_buf_d;
  logic [31:0]     last_pc_q, last_pc_d;
  logic            ld_ready_q, ld_ready_d;
  logic            prog_ready_q, prog_ready_d;
  logic            ld_error_q, ld_error_d;
  logic            rd_hit_q, rd_hit_d;

  logic            xfer;
  logic            ram_we;
  logic [DEPTH_LOG2-1:0] ram_waddr;
  logic [31:0]     ram_wdata;
  logic [31:0]     ram_rdata;

  // Next-state logic for the loader FSM, the byte packer and the fetch filter.
  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    wr_ptr_d     = wr_ptr_q;
    word_buf_d   = word_buf_q;
    last_pc_d    = last_pc_q;
    ram_we       = 1'b0;
    ram_waddr    = wr_ptr_q[DEPTH_LOG2-1:0];
    // Bytes 0..2 come from the buffer. Byte 3 comes straight off the bus, so
    // the word is written to the RAM in the same cycle that byte 3 arrives.
    ram_wdata    = {ld_data, word_buf_q};
    xfer         = ld_valid && ld_ready_q;

    if ((state_q == ST_LOAD) && xfer) begin
      if (wr_ptr_q == PTR_FULL) begin
        // The RAM is already full. Refuse the byte and never write.
        state_d = ST_ERR;
      end else begin
        case (byte_cnt_q)
          2'd0: word_buf_d[7:0]   = ld_data;
          2'd1: word_buf_d[15:8]  = ld_data;
          2'd2: word_buf_d[23:16] = ld_data;
          default: begin
            ram_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
        endcase
        byte_cnt_d = byte_cnt_q + 2'd1;
        if (ld_last) begin
          if (byte_cnt_q == 2'd3) begin
            state_d   = ST_DONE;
            last_pc_d = 32'(wr_ptr_q);
          end else begin
            // The last byte arrived before a word was complete.
            state_d = ST_ERR;
          end
        end
      end
    end

    ld_ready_d   = (state_d == ST_LOAD);
    prog_ready_d = (state_d == ST_DONE);
    ld_error_d   = (state_d == ST_ERR);

    // Decide at the sampling edge whether the RAM word or the NOP word is
    // shown. prog_ready_q is the value from before that edge.
    rd_hit_d = prog_ready_q && ((instr_addr >> DEPTH_LOG2) == 32'd0);
  end

  // Single state register for the FSM, the packer and the registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_LOAD;
      byte_cnt_q   <= 2'd0;
      wr_ptr_q     <= '0;
      word_buf_q   <= '0;
      last_pc_q    <= '0;
      ld_ready_q   <= 1'b1;
      prog_ready_q <= 1'b0;
      ld_error_q   <= 1'b0;
      rd_hit_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      word_buf_q   <= word_buf_d;
      last_pc_q    <= last_pc_d;
      ld_ready_q   <= ld_ready_d;
      prog_ready_q <= prog_ready_d;
      ld_error_q   <= ld_error_d;
      rd_hit_q     <= rd_hit_d;
    end
  end

  instr_mem_ram #(
    .AW (DEPTH_LOG2),
    .DW (32)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (instr_addr[DEPTH_LOG2-1:0]),
    .rdata (ram_rdata)
  );

  assign instr_data = rd_hit_q ? ram_rdata : NOP_WORD;
  assign last_pc    = last_pc_q;
  assign ld_ready   = ld_ready_q;
  assign prog_ready = prog_ready_q;
  assign ld_error   = ld_error_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_instr_mem.sv
// Testbench for instr_mem.
// It applies directed loader byte streams to two instances: the default
// depth and a 4-word instance used for the overflow case.
// Expected fetch results go into exp_q. A negedge monitor compares them one
// cycle after each fetch request.
module tb_instr_mem;
  import instr_mem_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Main instance (DEPTH_LOG2 = 10).
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [7:0]  ld_data = 8'h00;
  logic        ld_last = 1'b0;
  logic [31:0] instr_addr = 32'd0;
  logic [31:0] instr_data;
  logic [31:0] last_pc;
  logic        prog_ready;
  logic        ld_error;
  state_e      dbg_state;

  // Small instance (DEPTH_LOG2 = 2).
  logic        s_ld_valid = 1'b0;
  logic        s_ld_ready;
  logic [7:0]  s_ld_data = 8'h00;
  logic        s_ld_last = 1'b0;
  logic [31:0] s_instr_addr = 32'd0;
  logic [31:0] s_instr_data;
  logic [31:0] s_last_pc;
  logic        s_prog_ready;
  logic        s_ld_error;
  state_e      s_dbg_state;

  instr_mem dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .instr_addr (instr_addr),
    .instr_data (instr_data),
    .last_pc    (last_pc),
    .prog_ready (prog_ready),
    .ld_error   (ld_error),
    .dbg_state  (dbg_state)
  );

  instr_mem #(.DEPTH_LOG2(2)) dut_s (
    .clk        (clk),
    .rst_n      (rst_n),
    .ld_valid   (s_ld_valid),
    .ld_ready   (s_ld_ready),
    .ld_data    (s_ld_data),
    .ld_last    (s_ld_last),
    .instr_addr (s_instr_addr),
    .instr_data (s_instr_data),
    .last_pc    (s_last_pc),
    .prog_ready (s_prog_ready),
    .ld_error   (s_ld_error),
    .dbg_state  (s_dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];
  logic        rd_req = 1'b0;
  logic        rd_req_seen = 1'b0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Mark the edge at which a fetch address was presented.
  always @(posedge clk) rd_req_seen <= rd_req;

  // Monitor: instr_data is valid one cycle after a fetch request.
  always @(negedge clk) begin
    if (rd_req_seen) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL fetch_unexpected: got %h expected <none queued>", instr_data);
      end else begin
        logic [31:0] e;
        string n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        check32(n, instr_data, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Every task starts and ends at a falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic send_byte(input bit sel, input logic [7:0] b, input logic last);
    if (sel) begin
      s_ld_valid = 1'b1; s_ld_data = b; s_ld_last = last;
    end else begin
      ld_valid = 1'b1; ld_data = b; ld_last = last;
    end
    step();
    ld_valid = 1'b0; ld_data = 8'h00; ld_last = 1'b0;
    s_ld_valid = 1'b0; s_ld_data = 8'h00; s_ld_last = 1'b0;
  endtask

  // Idle cycle with ld_last held high and junk on the data bus.
  task automatic send_gap();
    ld_valid = 1'b0;
    ld_last  = 1'b1;
    ld_data  = 8'($urandom_range(0, 255));
    step();
    ld_last = 1'b0;
    ld_data = 8'h00;
  endtask

  task automatic fetch(input logic [31:0] addr, input logic [31:0] exp, input string name);
    instr_addr = addr;
    rd_req = 1'b1;
    exp_q.push_back(exp);
    name_q.push_back(name);
    step();
    rd_req = 1'b0;
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    #1;
    check32("rst_instr_data", instr_data, NOP);
    check32("rst_prog_ready", 32'(prog_ready), 32'd0);
    check32("rst_ld_error", 32'(ld_error), 32'd0);
    check32("rst_last_pc", last_pc, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check32("rst_ld_ready", 32'(ld_ready), 32'd1);
    check32("rst_state", 32'(dbg_state), 32'(ST_LOAD));
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] prog [12];

  initial begin
    prog = '{8'h13, 8'h00, 8'h00, 8'h00,
             8'h93, 8'h00, 8'h10, 8'h00,
             8'h37, 8'hC5, 8'hAB, 8'h12};

    do_reset();

    // Fetch before any program has been loaded.
    check32("pre_prog_ready", 32'(prog_ready), 32'd0);
    fetch(32'd0, NOP, "pre_fetch0");
    fetch(32'd5, NOP, "pre_fetch5");

    // Two-word load. A fetch is issued on the same edge as the DONE transition.
    for (int i = 0; i < 7; i++) send_byte(1'b0, prog[i], 1'b0);
    check32("mid_ld_ready", 32'(ld_ready), 32'd1);
    check32("mid_prog_ready", 32'(prog_ready), 32'd0);
    instr_addr = 32'd1;
    rd_req = 1'b1;
    exp_q.push_back(NOP);
    name_q.push_back("fetch_on_done_edge");
    send_byte(1'b0, prog[7], 1'b1);
    rd_req = 1'b0;
    check32("done_prog_ready", 32'(prog_ready), 32'd1);
    check32("done_ld_ready", 32'(ld_ready), 32'd0);
    check32("done_ld_error", 32'(ld_error), 32'd0);
    check32("done_last_pc", last_pc, 32'd1);
    check32("done_state", 32'(dbg_state), 32'(ST_DONE));
    fetch(32'd1, 32'h0010_0093, "fetch_word1");
    fetch(32'd0, 32'h0000_0013, "fetch_word0");
    fetch(32'd1024, NOP, "fetch_addr_depth");
    fetch(32'hFFFF_FFFF, NOP, "fetch_addr_max");
    // DONE is sticky: a further byte is refused.
    send_byte(1'b0, 8'hFF, 1'b1);
    check32("done_sticky_state", 32'(dbg_state), 32'(ST_DONE));
    check32("done_sticky_last_pc", last_pc, 32'd1);
    fetch(32'd1, 32'h0010_0093, "fetch_word1_again");

    // Partial final word: six bytes with last on the sixth.
    do_reset();
    for (int i = 0; i < 6; i++) send_byte(1'b0, 8'h11 * 8'(i + 1), i == 5);
    check32("err_ld_error", 32'(ld_error), 32'd1);
    check32("err_ld_ready", 32'(ld_ready), 32'd0);
    check32("err_prog_ready", 32'(prog_ready), 32'd0);
    check32("err_last_pc", last_pc, 32'd0);
    fetch(32'd0, NOP, "err_fetch0");
    fetch(32'd1, NOP, "err_fetch1");
    send_byte(1'b0, 8'h00, 1'b1);
    check32("err_sticky_state", 32'(dbg_state), 32'(ST_ERR));

    // Reset in the middle of a load discards the partial word.
    do_reset();
    send_byte(1'b0, 8'hEE, 1'b0);
    send_byte(1'b0, 8'hFF, 1'b0);
    do_reset();
    send_byte(1'b0, 8'hAA, 1'b0);
    send_byte(1'b0, 8'hBB, 1'b0);
    send_byte(1'b0, 8'hCC, 1'b0);
    send_byte(1'b0, 8'hDD, 1'b1);
    check32("rstmid_prog_ready", 32'(prog_ready), 32'd1);
    check32("rstmid_last_pc", last_pc, 32'd0);
    fetch(32'd0, 32'hDDCC_BBAA, "rstmid_fetch0");

    // Load with idle gaps and ld_last held high on the gap cycles.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      send_byte(1'b0, prog[i], i == 11);
      if (i != 11) send_gap();
    end
    check32("gap_prog_ready", 32'(prog_ready), 32'd1);
    check32("gap_last_pc", last_pc, 32'd2);
    fetch(32'd0, 32'h0000_0013, "gap_fetch0");
    fetch(32'd1, 32'h0010_0093, "gap_fetch1");
    fetch(32'd2, 32'h12AB_C537, "gap_fetch2");

    // Overflow on the 4-word instance: 16 bytes, then one more.
    do_reset();
    for (int k = 0; k < 16; k++) send_byte(1'b1, 8'h40 + 8'(k), 1'b0);
    check32("ovf_full_ld_ready", 32'(s_ld_ready), 32'd1);
    check32("ovf_full_ld_error", 32'(s_ld_error), 32'd0);
    send_byte(1'b1, 8'hEE, 1'b0);
    check32("ovf_ld_error", 32'(s_ld_error), 32'd1);
    check32("ovf_ld_ready", 32'(s_ld_ready), 32'd0);
    check32("ovf_prog_ready", 32'(s_prog_ready), 32'd0);
    check32("ovf_instr_data", s_instr_data, NOP);
    check32("ovf_mem0", dut_s.u_ram.mem[0], 32'h4342_4140);
    check32("ovf_mem1", dut_s.u_ram.mem[1], 32'h4746_4544);
    check32("ovf_mem2", dut_s.u_ram.mem[2], 32'h4B4A_4948);
    check32("ovf_mem3", dut_s.u_ram.mem[3], 32'h4F4E_4D4C);

    // Drain the scoreboard within a bounded number of cycles.
    for (int w = 0; w < 20 && exp_q.size() != 0; w++) step();
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net against a hung run.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/instr_mem.md
INSTR_MEM -- requirements
Module: instr_mem

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 10, log2 of memory depth in 32-bit words (DEPTH = 2**DEPTH_LOG2).
REQ-002 SHALL have parameter NOP_WORD, default 32'h00000013, the word returned whenever no valid program word is available.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 ld_valid  input  1  loader byte valid.
REQ-006 ld_ready  output  1  block accepts a loader byte.
REQ-007 ld_data  input  8  program byte.
REQ-008 ld_last  input  1  qualifies ld_data as the final program byte.
REQ-009 instr_addr  input  32  core fetch word address (next PC).
REQ-010 instr_data  output  32  fetched instruction, registered.
REQ-011 last_pc  output  32  word index of the last loaded instruction.
REQ-012 prog_ready  output  1  program fully loaded; core may execute.
REQ-013 ld_error  output  1  load failed (overflow or partial final word).

Function
REQ-014 SHALL implement a state machine with states LOAD, DONE and ERR.
REQ-015 LOAD -> DONE on an accepted ld_last byte that completes a word; LOAD -> ERR on an accepted ld_last byte that does not complete a word, or on an accepted byte while the write pointer equals DEPTH; DONE and ERR SHALL be sticky until reset.
REQ-016 A byte transfer SHALL occur only in a cycle where ld_valid and ld_ready are both 1; ld_ready SHALL be 1 exactly in LOAD.
REQ-017 Bytes SHALL be packed little-endian: the k-th byte of a word (k = 0..3) goes to bits [8k+7:8k]; a 2-bit byte counter SHALL wrap 3 -> 0.
REQ-018 On the transfer of byte 3, the assembled word SHALL be written to memory at the write pointer in the same cycle, and the pointer (DEPTH_LOG2+1 bits) SHALL increment.
REQ-019 On the DONE transition, last_pc SHALL be loaded with the zero-extended index of the word just written.
REQ-020 Reads SHALL be synchronous with 1-cycle latency: instr_data after edge N reflects instr_addr sampled at edge N.
REQ-021 instr_data SHALL equal NOP_WORD when prog_ready was 0 at the sampling edge, or when instr_addr >= DEPTH; otherwise it SHALL be mem[instr_addr].
REQ-022 prog_ready SHALL be 1 exactly in DONE; ld_error SHALL be 1 exactly in ERR.
REQ-023 Writes beyond DEPTH words SHALL never modify memory contents.
REQ-024 ld_last SHALL be ignored in any cycle without a transfer.

Reset
REQ-025 Asserting rst_n low SHALL immediately force the state to LOAD, the byte counter and write pointer to 0, last_pc to 0, instr_data to NOP_WORD, prog_ready to 0, ld_error to 0, and ld_ready to 1 after release.
REQ-026 Reset mid-load SHALL discard the partial word; memory array contents are not cleared and SHALL NOT be relied on.

Structure
REQ-027 A shared package SHALL hold the state encoding, NOP_WORD and the default DEPTH_LOG2.
REQ-028 Storage SHALL be a single sub-module, instr_mem_ram: a simple dual-port RAM (one synchronous write port, one synchronous read port) of DEPTH x 32; the FSM and packer live in instr_mem.

Verification
REQ-029 Load bytes 13,00,00,00,93,00,10,00 (last on 8th) -> prog_ready=1, last_pc=1; instr_addr=1 gives instr_data=32'h00100093 one cycle later.
REQ-030 Before any load, with instr_addr=0 -> instr_data=32'h00000013 and prog_ready=0.
REQ-031 Six bytes with ld_last on the 6th -> ld_error=1, ld_ready=0, prog_ready=0, and instr_data stays 32'h00000013.
REQ-032 With DEPTH_LOG2=2, 16 bytes without ld_last followed by one further byte -> ld_error=1; mem[0..3] remain intact.
REQ-033 Drop rst_n after 2 bytes, release it, then load 4 bytes AA,BB,CC,DD with last -> mem[0]=32'hDDCCBBAA, last_pc=0.
REQ-034 Toggle ld_valid with idle gaps and hold ld_last high on non-transfer cycles -> packed words are identical to those from a gap-free load.
